// File: rtl/ex_mem_flag_pipe_pkg.sv
// Shared definitions for the EX/MEM register and flag logic.
// Opcode map, flag bit positions and default widths.
package ex_mem_flag_pipe_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 4;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  // flags vector is {Z,V,N}
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/ex_mem_flag_pipe_flag_update_logic.sv
// Next-state logic for the {Z,V,N} flag register.
// Purely combinational; the caller owns the flops.
module flag_update_logic
  import ex_mem_flag_pipe_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [3:0]    i_opcode,
  input  logic [DW-1:0] i_alu,
  input  logic          i_ovf,
  input  logic          i_accept,
  input  logic [2:0]    i_flags,
  output logic [2:0]    o_flags
);

  logic w_arith;
  logic w_zonly;
  logic w_zero;

  assign w_arith = (i_opcode == OP_ADD) |
                   (i_opcode == OP_SUB);
  assign w_zonly = (i_opcode == OP_XOR) |
                   (i_opcode == OP_SLL) |
                   (i_opcode == OP_SRA) |
                   (i_opcode == OP_ROR);
  assign w_zero  = (i_alu == '0);

  always_comb begin
    o_flags = i_flags;
    if (i_accept) begin
      unique case (1'b1)
        w_arith: begin
          o_flags[FLAG_Z] = w_zero;
          o_flags[FLAG_V] = i_ovf;
          o_flags[FLAG_N] = i_alu[DW-1];
        end
        w_zonly: o_flags[FLAG_Z] = w_zero;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_flag_pipe.sv
// EX/MEM pipeline register with the processor flag register
// and a sticky halt latch that drains MEM after HLT.
module ex_mem_flag_pipe
  import ex_mem_flag_pipe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [3:0]    ex_opcode,
  input  logic [DW-1:0] ex_alu_out,
  input  logic          ex_ovf,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_we,
  input  logic          ex_mem_we,
  input  logic          ex_mem_re,
  input  logic          ex_halt,
  output logic          mem_valid,
  output logic [DW-1:0] mem_alu_out,
  output logic [DW-1:0] mem_store_data,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_we,
  output logic          mem_mem_we,
  output logic          mem_mem_re,
  output logic          mem_halt,
  output logic [2:0]    flags,
  output logic          halted
);

  logic          r_valid;
  logic [DW-1:0] r_alu;
  logic [DW-1:0] r_sdata;
  logic [RW-1:0] r_rd;
  logic          r_reg_we;
  logic          r_mem_we;
  logic          r_mem_re;
  logic          r_halt;
  logic [2:0]    r_flags;
  logic          r_halted;

  logic          w_accept;
  logic [2:0]    w_flags_nxt;

  assign w_accept = ex_valid & ~stall & ~flush & ~r_halted;

  flag_update_logic #(
    .DW (DW)
  ) u_flags (
    .i_opcode (ex_opcode),
    .i_alu    (ex_alu_out),
    .i_ovf    (ex_ovf),
    .i_accept (w_accept),
    .i_flags  (r_flags),
    .o_flags  (w_flags_nxt)
  );

  // Data fields load unconditionally; only control is gated to form bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_alu    <= '0;
      r_sdata  <= '0;
      r_rd     <= '0;
      r_reg_we <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_halt   <= 1'b0;
      r_flags  <= 3'b000;
      r_halted <= 1'b0;
    end else if (!stall) begin
      r_valid  <= w_accept;
      r_alu    <= ex_alu_out;
      r_sdata  <= ex_store_data;
      r_rd     <= ex_rd;
      r_reg_we <= w_accept & ex_reg_we;
      r_mem_we <= w_accept & ex_mem_we;
      r_mem_re <= w_accept & ex_mem_re;
      r_halt   <= w_accept & ex_halt;
      r_flags  <= w_flags_nxt;
      if (w_accept && ex_halt) r_halted <= 1'b1;
    end
  end

  assign mem_valid      = r_valid;
  assign mem_alu_out    = r_alu;
  assign mem_store_data = r_sdata;
  assign mem_rd         = r_rd;
  assign mem_reg_we     = r_reg_we;
  assign mem_mem_we     = r_mem_we;
  assign mem_mem_re     = r_mem_re;
  assign mem_halt       = r_halt;
  assign flags          = r_flags;
  assign halted         = r_halted;

endmodule

// File: tb/tb_ex_mem_flag_pipe.sv
// Directed-vector bench for ex_mem_flag_pipe.
// Expected values are hand-computed per vector.
module tb_ex_mem_flag_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_alu_out, ex_store_data;
  logic        ex_ovf;
  logic [3:0]  ex_rd;
  logic        ex_reg_we, ex_mem_we, ex_mem_re, ex_halt;
  logic        mem_valid;
  logic [15:0] mem_alu_out, mem_store_data;
  logic [3:0]  mem_rd;
  logic        mem_reg_we, mem_mem_we, mem_mem_re, mem_halt;
  logic [2:0]  flags;
  logic        halted;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem_flag_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_alu_out     (ex_alu_out),
    .ex_ovf         (ex_ovf),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_reg_we      (ex_reg_we),
    .ex_mem_we      (ex_mem_we),
    .ex_mem_re      (ex_mem_re),
    .ex_halt        (ex_halt),
    .mem_valid      (mem_valid),
    .mem_alu_out    (mem_alu_out),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_reg_we     (mem_reg_we),
    .mem_mem_we     (mem_mem_we),
    .mem_mem_re     (mem_mem_re),
    .mem_halt       (mem_halt),
    .flags          (flags),
    .halted         (halted)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [15:0] alu,
                       input logic ovf,
                       input logic [15:0] sd,
                       input logic [3:0] rd,
                       input logic rwe, mwe, mre, hlt);
    ex_valid      = 1'b1;
    ex_opcode     = op;
    ex_alu_out    = alu;
    ex_ovf        = ovf;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_reg_we     = rwe;
    ex_mem_we     = mwe;
    ex_mem_re     = mre;
    ex_halt       = hlt;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(4'h0, 16'h0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex_valid = 1'b0;
    #12 rst = 1'b0;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // ADD result zero
    drive(4'h0, 16'h0000, 1'b0, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("add_flags", 32'(flags), 32'b100);
    chk("add_valid", 32'(mem_valid), 32'd1);
    chk("add_rd", 32'(mem_rd), 32'd3);

    // XOR: only Z updates
    drive(4'h2, 16'h8000, 1'b0, 16'h0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("xor_flags", 32'(flags), 32'b000);

    // stalled SUB holds everything
    drive(4'h1, 16'h8000, 1'b1, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    step();
    chk("stall1_flags", 32'(flags), 32'b000);
    chk("stall1_rd", 32'(mem_rd), 32'd4);
    step();
    chk("stall2_flags", 32'(flags), 32'b000);
    chk("stall2_alu", 32'(mem_alu_out), 32'h8000);
    stall = 1'b0;
    step();
    chk("sub_flags", 32'(flags), 32'b011);
    chk("sub_rd", 32'(mem_rd), 32'd5);

    // flushed ADD becomes a bubble, flags hold
    drive(4'h0, 16'h0000, 1'b0, 16'h0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(mem_valid), 32'd0);
    chk("flush_rwe", 32'(mem_reg_we), 32'd0);
    chk("flush_flags", 32'(flags), 32'b011);

    flush = 1'b0;
    drive(4'h0, 16'h1234, 1'b0, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("add2_flags", 32'(flags), 32'b000);
    chk("add2_valid", 32'(mem_valid), 32'd1);

    // flush with stall: stall wins
    drive(4'h0, 16'h0000, 1'b0, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1; stall = 1'b1;
    step();
    chk("fs_valid", 32'(mem_valid), 32'd1);
    chk("fs_alu", 32'(mem_alu_out), 32'h1234);
    chk("fs_flags", 32'(flags), 32'b000);
    flush = 1'b0; stall = 1'b0;

    ex_valid = 1'b0;
    step();
    chk("bubble_valid", 32'(mem_valid), 32'd0);
    chk("bubble_flags", 32'(flags), 32'b000);

    // back-to-back SW then LW
    drive(4'h9, 16'h0010, 1'b0, 16'hBEEF, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("sw_we", 32'(mem_mem_we), 32'd1);
    chk("sw_addr", 32'(mem_alu_out), 32'h0010);
    chk("sw_data", 32'(mem_store_data), 32'hBEEF);
    chk("sw_rwe", 32'(mem_reg_we), 32'd0);
    drive(4'h8, 16'h0020, 1'b0, 16'h0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("lw_re", 32'(mem_mem_re), 32'd1);
    chk("lw_we", 32'(mem_mem_we), 32'd0);
    chk("lw_rd", 32'(mem_rd), 32'd7);
    chk("lw_addr", 32'(mem_alu_out), 32'h0020);
    chk("lw_flags", 32'(flags), 32'b000);

    // saturated ADD, then RED (no change), then SLL zero
    drive(4'h0, 16'h7FFF, 1'b1, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("sat_flags", 32'(flags), 32'b010);
    drive(4'h3, 16'h0000, 1'b0, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("red_flags", 32'(flags), 32'b010);
    drive(4'h4, 16'h0000, 1'b0, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("sll_flags", 32'(flags), 32'b110);

    // HLT then ADD
    drive(4'hF, 16'h0000, 1'b0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("hlt_mhalt", 32'(mem_halt), 32'd1);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_valid", 32'(mem_valid), 32'd1);
    drive(4'h0, 16'h0000, 1'b0, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("post_valid", 32'(mem_valid), 32'd0);
    chk("post_mhalt", 32'(mem_halt), 32'd0);
    chk("post_rwe", 32'(mem_reg_we), 32'd0);
    chk("post_halted", 32'(halted), 32'd1);
    chk("post_flags", 32'(flags), 32'b110);
    step();
    chk("post2_halted", 32'(halted), 32'd1);

    // async reset mid-cycle
    rst = 1'b1;
    #2 rst = 1'b0;
    drive(4'h0, 16'h8001, 1'b0, 16'h0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("rel_valid", 32'(mem_valid), 32'd1);
    chk("rel_flags", 32'(flags), 32'b001);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(mem_valid), 32'd0);
    chk("arst_rd", 32'(mem_rd), 32'd0);
    chk("arst_alu", 32'(mem_alu_out), 32'd0);
    chk("arst_rwe", 32'(mem_reg_we), 32'd0);
    chk("arst_flags", 32'(flags), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    #10 rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
